// File: rtl/mult_sequencer.sv
// Sequential IN_W x IN_W unsigned multiplier that time-shares one external
// 4x4 multiplier, feeding one nibble pair per cycle and accumulating partials.
module mult_sequencer #(
   parameter int IN_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IN_W-1:0]   a,
   input  logic [IN_W-1:0]   b,
   output logic              busy,
   output logic              done,
   output logic [2*IN_W-1:0] p,
   output logic [3:0]        mul_a,
   output logic [3:0]        mul_b,
   input  logic [7:0]        mul_c
);

   localparam int             K    = IN_W / 4;
   localparam int             PW   = 2 * IN_W;
   localparam logic [1:0]     LAST = 2'(K - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        i_q, i_d;
   logic [1:0]        j_q, j_d;
   logic [IN_W-1:0]   a_q, a_d;
   logic [IN_W-1:0]   b_q, b_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     p_q, p_d;
   logic              done_q, done_d;
   logic [PW-1:0]     partial;
   logic [PW-1:0]     sum;

   // i walks the multiplicand nibbles, j the multiplier nibbles (j fastest).
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      if (state_q == RUN) begin
         mul_a = a_q[4*i_q +: 4];
         mul_b = b_q[4*j_q +: 4];
      end
      partial = PW'(mul_c) << (4 * (i_q + j_q));
      sum     = acc_q + partial;
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch can be inferred.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      p_d     = p_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = sum;
            if (j_q == LAST) begin
               j_d = '0;
               i_d = i_q + 2'd1;
            end else begin
               j_d = j_q + 2'd1;
            end
            if ((i_q == LAST) && (j_q == LAST)) begin
               p_d     = sum;
               done_d  = 1'b1;
               i_d     = '0;
               j_d     = '0;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         p_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         p_q     <= p_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign p    = p_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: an 8-bit and a 16-bit instance, each with a
// behavioural 4x4 multiplier, checked against plain-arithmetic expectations.
module tb_mult_sequencer;

   logic        clk = 1'b0;
   logic        rst;

   logic        start8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic [3:0]  ma8, mb8;
   logic [7:0]  mc8;

   logic        start16, busy16, done16;
   logic [15:0] a16, b16;
   logic [31:0] p16;
   logic [3:0]  ma16, mb16;
   logic [7:0]  mc16;

   int checks = 0;
   int errors = 0;
   logic [15:0] last_p8;

   always #5 clk = ~clk;

   assign mc8  = {4'h0, ma8}  * {4'h0, mb8};
   assign mc16 = {4'h0, ma16} * {4'h0, mb16};

   mult_sequencer #(.IN_W(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .p(p8),
      .mul_a(ma8), .mul_b(mb8), .mul_c(mc8)
   );

   mult_sequencer #(.IN_W(16)) u16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .p(p16),
      .mul_a(ma16), .mul_b(mb16), .mul_c(mc16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One 8-bit operation; with noise, start is asserted with FF operands
   // throughout RUN and DONE, which must not disturb anything.
   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit noise);
      logic [15:0] exp_p;
      logic [3:0]  na, nb;
      exp_p  = 16'(av) * 16'(bv);
      start8 = 1'b1;
      a8     = av;
      b8     = bv;
      tick();
      start8 = noise;
      a8     = noise ? 8'hFF : 8'($urandom);
      b8     = noise ? 8'hFF : 8'($urandom);
      for (int k = 0; k < 4; k++) begin
         na = 4'((av >> (4 * (k / 2))) & 8'hF);
         nb = 4'((bv >> (4 * (k % 2))) & 8'hF);
         check("run_mul_a", 32'(ma8), 32'(na));
         check("run_mul_b", 32'(mb8), 32'(nb));
         check("run_busy", 32'(busy8), 32'd1);
         check("run_done", 32'(done8), 32'd0);
         check("run_p_hold", 32'(p8), 32'(last_p8));
         tick();
      end
      check("done_pulse", 32'(done8), 32'd1);
      check("done_busy", 32'(busy8), 32'd1);
      check("done_p", 32'(p8), 32'(exp_p));
      check("done_mul_a", 32'(ma8), 32'd0);
      check("done_mul_b", 32'(mb8), 32'd0);
      tick();
      start8 = 1'b0;
      check("idle_done", 32'(done8), 32'd0);
      check("idle_busy", 32'(busy8), 32'd0);
      check("idle_p", 32'(p8), 32'(exp_p));
      last_p8 = exp_p;
   endtask

   initial begin
      int cnt;
      rst     = 1'b1;
      start8  = 1'b0;
      a8      = '0;
      b8      = '0;
      start16 = 1'b0;
      a16     = '0;
      b16     = '0;
      last_p8 = '0;
      tick();
      tick();
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_p", 32'(p8), 32'd0);
      check("rst_mul_a", 32'(ma8), 32'd0);
      check("rst_mul_b", 32'(mb8), 32'd0);
      check("rst_busy16", 32'(busy16), 32'd0);
      check("rst_p16", p16, 32'd0);
      rst = 1'b0;
      tick();

      op8(8'h12, 8'h34, 1'b0);
      check("p_12x34", 32'(p8), 32'h03A8);
      op8(8'hFF, 8'hFF, 1'b0);
      op8(8'h00, 8'hAB, 1'b0);
      op8(8'h05, 8'h07, 1'b1);
      check("p_ignored_start", 32'(p8), 32'h0023);

      // Reset in the second RUN cycle discards the operation.
      start8 = 1'b1;
      a8     = 8'h99;
      b8     = 8'h77;
      tick();
      start8 = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", 32'(busy8), 32'd0);
      check("midrst_p", 32'(p8), 32'd0);
      check("midrst_done", 32'(done8), 32'd0);
      check("midrst_mul_a", 32'(ma8), 32'd0);
      tick();
      tick();
      check("midrst_no_done", 32'(done8), 32'd0);
      last_p8 = '0;
      op8(8'h0A, 8'h0B, 1'b0);

      for (int n = 0; n < 8; n++) begin
         op8(8'($urandom), 8'($urandom), n[0]);
      end

      // 16-bit instance with start held high across two operations.
      start16 = 1'b1;
      a16     = 16'hFFFF;
      b16     = 16'hFFFF;
      tick();
      cnt = 0;
      while (done16 !== 1'b1 && cnt < 40) begin
         tick();
         cnt++;
      end
      check("w16_latency", 32'(cnt), 32'd16);
      check("w16_p", p16, 32'hFFFE0001);
      check("w16_busy_done", 32'(busy16), 32'd1);
      tick();
      check("w16_idle_gap_busy", 32'(busy16), 32'd0);
      check("w16_idle_gap_done", 32'(done16), 32'd0);
      a16 = 16'h1234;
      b16 = 16'hABCD;
      tick();
      start16 = 1'b0;
      check("w16_restart_busy", 32'(busy16), 32'd1);
      check("w16_restart_mul_a", 32'(ma16), 32'h4);
      check("w16_restart_mul_b", 32'(mb16), 32'hD);
      check("w16_p_held", p16, 32'hFFFE0001);
      cnt = 0;
      while (done16 !== 1'b1 && cnt < 40) begin
         tick();
         cnt++;
      end
      check("w16_latency2", 32'(cnt), 32'd16);
      check("w16_p2", p16, 32'(32'h1234 * 32'hABCD));
      tick();
      check("w16_end_busy", 32'(busy16), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
